// File: rtl/dmem_arb_pkg.sv
// Shared types and default bus widths for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W = 12;
  localparam int DMEM_DATA_W = 32;
  localparam int WAIT_CNT_W  = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_AUX  = 2'd2
  } owner_t;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating up-counter with synchronous clear; counts consecutive denied
// aux-request cycles.
module starve_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] wait_cnt
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (clr) begin
      wait_cnt <= '0;
    end else if (inc && (wait_cnt != '1)) begin
      wait_cnt <= wait_cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port dmem between the processor (fixed priority) and an
// aux master, with a starvation bound and owner-tagged read return.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] aux_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  force_aux;
  logic                  aux_denied;
  owner_t                owner_q;
  owner_t                owner_d;

  starve_counter #(.WIDTH(WAIT_CNT_W)) u_starve (
    .clock    (clock),
    .reset    (reset),
    .inc      (aux_denied),
    .clr      (~aux_denied),
    .wait_cnt (wait_cnt)
  );

  // Grants are masked by reset so nothing reaches dmem while reset is high.
  assign force_aux  = aux_req & (wait_cnt >= WAIT_CNT_W'(MAX_WAIT));
  assign aux_gnt    = ~reset & aux_req & (~cpu_req | force_aux);
  assign cpu_gnt    = ~reset & cpu_req & ~aux_gnt;
  assign cpu_stall  = ~reset & cpu_req & ~cpu_gnt;
  assign aux_denied = aux_req & ~aux_gnt;

  always_comb begin
    mem_address = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;
    if (cpu_gnt) begin
      mem_address = cpu_addr;
      mem_data    = cpu_wdata;
      mem_wren    = cpu_we;
    end else if (aux_gnt) begin
      mem_address = aux_addr;
      mem_data    = aux_wdata;
      mem_wren    = aux_we;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (cpu_gnt && !cpu_we) begin
      owner_d = OWN_CPU;
    end else if (aux_gnt && !aux_we) begin
      owner_d = OWN_AUX;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign cpu_rvalid = (owner_q == OWN_CPU);
  assign aux_rvalid = (owner_q == OWN_AUX);
  assign cpu_rdata  = cpu_rvalid ? mem_q : '0;
  assign aux_rdata  = aux_rvalid ? mem_q : '0;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port data memory between the processor and an auxiliary master (display/game-logic reader or keyboard writer). The processor has fixed priority. A starvation counter guarantees the auxiliary master a slot after a bounded wait. Read data is returned to whichever master owned the slot. The block sits between `processor`/aux logic and `dmem` inside `cpu`, and its stall output feeds the processor's block signal.

## Interface
- `ADDR_W`, 12, dmem word-address width
- `DATA_W`, 32, dmem data width
- `MAX_WAIT`, 4, consecutive denied aux-request cycles before aux is force-granted (1..15)
- `clock`  in  1  single system clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `cpu_req` / `cpu_we`  in  1 / 1  processor access request / write enable
- `cpu_addr` / `cpu_wdata`  in  ADDR_W / DATA_W  processor address / write data
- `cpu_gnt`  out  1  processor access accepted this cycle (combinational)
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`
- `cpu_rvalid` / `cpu_rdata`  out  1 / DATA_W  processor read return
- `aux_req`, `aux_we`, `aux_addr`, `aux_wdata`, `aux_gnt`, `aux_rvalid`, `aux_rdata`: same roles for the aux master
- `mem_address` / `mem_data` / `mem_wren`  out  ADDR_W / DATA_W / 1  to dmem
- `mem_q`  in  DATA_W  dmem read data, valid the cycle after the address is presented

## Operation
- **Grant rule** (combinational, evaluated every cycle):
  - `force_aux = aux_req & (wait_cnt >= MAX_WAIT)`.
  - `aux_gnt = aux_req & (~cpu_req | force_aux)`.
  - `cpu_gnt = cpu_req & ~aux_gnt`.
  - At most one grant per cycle.
- **Mux:** memory outputs take the granted master's address, data and `we`. With no grant: `mem_address=0`, `mem_data=0`, `mem_wren=0`.
- **wait_cnt** (4-bit, saturating at 15):
  - Increments when `aux_req & ~aux_gnt`.
  - Clears on `aux_gnt` or when `~aux_req`.
- **owner register** (OWN_NONE / OWN_CPU / OWN_AUX) records the master of a granted read (`gnt & ~we`). A write or an idle cycle loads OWN_NONE.
- **Read return:**
  - `x_rvalid = (owner == OWN_x)`.
  - `x_rdata = mem_q` when the matching rvalid is high, else 0.
- Writes generate no rvalid.
- While `reset` is high: all grants are 0, `mem_wren=0`, and `owner`/`wait_cnt` are cleared.

## Timing
- **Reset values:** `cpu_gnt`, `aux_gnt`, `cpu_stall`, `cpu_rvalid`, `aux_rvalid` and `mem_wren` are 0; rdata and memory buses are 0; `wait_cnt=0`; `owner=OWN_NONE`.
- **Grant latency:** 0 cycles (grant in the same cycle as req). A request must be held until granted; the master drops or changes it in the cycle after `gnt`.
- **Read latency:** `rvalid` and `rdata` appear exactly 1 cycle after the granted read cycle. Back-to-back reads from alternating masters are supported at 1 access per cycle.
- **Simultaneous requests:** the CPU wins unless `force_aux`. A forced aux slot stalls the CPU for exactly 1 cycle, after which `wait_cnt=0` and the CPU regains priority.
- **Worst-case aux wait:** MAX_WAIT cycles of denial, granted in cycle MAX_WAIT+1.
- **Reset mid-read:** a pending return is discarded. `rvalid` is 0 in the cycle after reset is released.
- **Deassertion:** an aux request that deasserts while waiting clears `wait_cnt`; no credit is carried over.

## Structure
- **Package `dmem_arb_pkg`:** owner enum (OWN_NONE=0, OWN_CPU=1, OWN_AUX=2), default `ADDR_W`/`DATA_W` constants.
- **Sub-module `starve_counter`:** saturating up-counter with clear and async reset, parameterised on width. It outputs `wait_cnt`.
- Everything else (grant logic, mux, owner register, return routing) lives flat in `dmem_arbiter`.

## Test plan
- **Reset:** assert reset mid-cycle with `cpu_req=1` -> all outputs 0 immediately; after release, `cpu_rvalid=0`.
- **CPU-only read:** CPU reads addr 0x010 holding 0xDEADBEEF -> `cpu_gnt=1` in cycle 0; `cpu_rvalid=1` with `cpu_rdata=0xDEADBEEF` in cycle 1; `aux_rvalid=0`.
- **Aux write while idle CPU:** aux writes 0x00000007 to addr 0x3FF -> `mem_wren=1`, `mem_address=0x3FF` in the grant cycle; no rvalid on either port; a subsequent CPU read of 0x3FF returns 7.
- **Starvation:** `cpu_req` and `aux_req` held high with MAX_WAIT=4 -> aux denied in cycles 0-3, `aux_gnt=1` and `cpu_stall=1` in cycle 4, CPU granted in cycle 5, pattern repeats every 5 cycles.
- **Alternating reads:** CPU read 0x001 in cycle 0, forced aux read 0x002 in cycle 1 -> cycle 1 returns to the CPU only, cycle 2 returns to aux only; data is never cross-routed.
- **Request withdrawal:** aux waits 3 cycles then drops `aux_req` -> `wait_cnt` reads 0 next cycle; a re-request with the CPU busy waits the full 4 cycles again.
